// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB responder.
package sccb_pkg;

    localparam logic [7:0] SCCB_DEFAULT_ID = 8'h42;
    localparam int         BIT_CNT_W       = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ID,
        ST_SUB,
        ST_WDATA,
        ST_RDATA,
        ST_IGNORE
    } sccb_state_e;

endpackage

// File: rtl/sccb_line_filter.sv
// Synchronizes one SCCB line, rejects glitches shorter than FILTER_LEN clk
// samples and produces one-cycle rise/fall strobes. Resets to idle-high.
module sccb_line_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic line_in,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    // The level flips only after FILTER_LEN consecutive disagreeing samples.
    always_comb begin
        sync_d  = {sync_q[0], line_in};
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q[1];
                rise_d  = sync_q[1];
                fall_d  = ~sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            level_q <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/sccb_responder.sv
// SCCB register-port responder (write ID DEVICE_ID, read ID DEVICE_ID|1).
// Read support is compiled in only when SCCB_RESPONDER_READ_EN is defined.
module sccb_responder
    import sccb_pkg::*;
#(
    parameter logic [7:0] DEVICE_ID  = SCCB_DEFAULT_ID,
    parameter int         FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sio_c,
    input  logic       sio_d_in,
    output logic       sio_d_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wr_data,
    output logic       reg_wr_en,
    input  logic [7:0] reg_rd_data,
    output logic       busy
);

    logic sc_level, sc_rise, sc_fall;
    logic sd_level, sd_rise, sd_fall;

    sccb_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_c (
        .clk(clk), .rst(rst), .line_in(sio_c),
        .level(sc_level), .rise(sc_rise), .fall(sc_fall)
    );

    sccb_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_d (
        .clk(clk), .rst(rst), .line_in(sio_d_in),
        .level(sd_level), .rise(sd_rise), .fall(sd_fall)
    );

    logic start_det, stop_det;
    assign start_det = sd_fall & sc_level;
    assign stop_det  = sd_rise & sc_level;

    sccb_state_e          state_q, state_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]           shift_q, shift_d;
    logic [7:0]           reg_addr_q, reg_addr_d;
    logic [7:0]           reg_wr_data_q, reg_wr_data_d;
    logic                 reg_wr_en_q, reg_wr_en_d;
    logic [7:0]           rx_byte;

    assign rx_byte = {shift_q[6:0], sd_level};

`ifdef SCCB_RESPONDER_READ_EN
    localparam logic [7:0] READ_ID = DEVICE_ID | 8'h01;
    logic [7:0] rd_shift_q, rd_shift_d;
    logic       rd_active_q, rd_active_d;
    logic       sio_d_oe_q, sio_d_oe_d;
`endif

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        reg_addr_d    = reg_addr_q;
        reg_wr_data_d = reg_wr_data_q;
        reg_wr_en_d   = 1'b0;
`ifdef SCCB_RESPONDER_READ_EN
        rd_shift_d    = rd_shift_q;
        rd_active_d   = rd_active_q;
        sio_d_oe_d    = sio_d_oe_q;
`endif

        // Bit counter runs 0..8; the ninth (ack/NA) bit only rewinds it.
        if (sc_rise && state_q != ST_IDLE) begin
            if (bit_cnt_q == BIT_CNT_W'(8)) begin
                bit_cnt_d = '0;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
                shift_d   = rx_byte;
                if (bit_cnt_q == BIT_CNT_W'(7)) begin
                    case (state_q)
                        ST_ID: begin
                            if (rx_byte == DEVICE_ID)
                                state_d = ST_SUB;
`ifdef SCCB_RESPONDER_READ_EN
                            else if (rx_byte == READ_ID)
                                state_d = ST_RDATA;
`endif
                            else
                                state_d = ST_IGNORE;
                        end
                        ST_SUB: begin
                            reg_addr_d = rx_byte;
                            state_d    = ST_WDATA;
                        end
                        ST_WDATA: begin
                            reg_wr_data_d = rx_byte;
                            reg_wr_en_d   = 1'b1;
                            state_d       = ST_IGNORE;
                        end
                        default: ;
                    endcase
                end
            end
        end

`ifdef SCCB_RESPONDER_READ_EN
        // Read byte: the fall ending the ID ack loads the byte and drives bit 7;
        // later falls walk down to bit 0, and the fall after the 8th rise releases.
        if (sc_fall && state_q == ST_RDATA) begin
            if (!rd_active_q) begin
                if (bit_cnt_q == '0) begin
                    rd_active_d = 1'b1;
                    rd_shift_d  = reg_rd_data;
                    sio_d_oe_d  = ~reg_rd_data[7];
                end
            end else if (bit_cnt_q == BIT_CNT_W'(8)) begin
                rd_active_d = 1'b0;
                sio_d_oe_d  = 1'b0;
                state_d     = ST_IGNORE;
            end else begin
                rd_shift_d = rd_shift_q << 1;
                sio_d_oe_d = ~rd_shift_q[6];
            end
        end
`endif

        if (stop_det) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
`ifdef SCCB_RESPONDER_READ_EN
            rd_active_d = 1'b0;
            sio_d_oe_d  = 1'b0;
`endif
        end else if (start_det) begin
            state_d   = ST_ID;
            bit_cnt_d = '0;
`ifdef SCCB_RESPONDER_READ_EN
            rd_active_d = 1'b0;
            sio_d_oe_d  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            reg_addr_q    <= '0;
            reg_wr_data_q <= '0;
            reg_wr_en_q   <= 1'b0;
`ifdef SCCB_RESPONDER_READ_EN
            rd_shift_q    <= '0;
            rd_active_q   <= 1'b0;
            sio_d_oe_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            reg_addr_q    <= reg_addr_d;
            reg_wr_data_q <= reg_wr_data_d;
            reg_wr_en_q   <= reg_wr_en_d;
`ifdef SCCB_RESPONDER_READ_EN
            rd_shift_q    <= rd_shift_d;
            rd_active_q   <= rd_active_d;
            sio_d_oe_q    <= sio_d_oe_d;
`endif
        end
    end

`ifdef SCCB_RESPONDER_READ_EN
    assign sio_d_oe = sio_d_oe_q;
`else
    logic unused_rd;
    assign unused_rd = ^{reg_rd_data, sc_fall};
    assign sio_d_oe  = 1'b0;
`endif

    assign reg_addr    = reg_addr_q;
    assign reg_wr_data = reg_wr_data_q;
    assign reg_wr_en   = reg_wr_en_q;
    assign busy        = (state_q != ST_IDLE);

endmodule
